cdc_handshake_tx: RTL and testbench

Source-side launcher for the synchronizer's strobe-qualified and pulse modes. It accepts 8-bit words on a valid/ready port in its own clock domain and holds each word stable on `tx_data`. It then raises a request toward the destination domain and completes a full request/acknowledge handshake before it accepts the next word. It sits in front of the receiving synchronizer and gives that synchronizer data that is guaranteed stable around the qualifying strobe.

---
 rtl/cdc_handshake_tx.sv | 115 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-side launcher: holds each accepted word on tx_data across a full req/ack handshake.
// Default is four-phase; define CDC_TX_TOGGLE_EN for the two-phase (toggle) protocol.
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             busy,
  output logic [7:0]       sent_count
);

`ifdef CDC_TX_TOGGLE_EN
  typedef enum logic [1:0] {IDLE, SETUP, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;
`endif

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [2:0]             settle_cnt;
  logic                   settled;
  logic                   req_nxt;
  logic                   done;
  logic                   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // After reset the synchronizer holds zeros, not the receiver's real ack level;
  // acceptance waits until the chain has been refilled from tx_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        settle_cnt <= '0;
    else if (!settled) settle_cnt <= settle_cnt + 3'd1;
  end

  assign settled = (settle_cnt == 3'(SYNC_STAGES));

  always_comb begin
    state_nxt = state;
    req_nxt   = tx_req;
    done      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
`ifdef CDC_TX_TOGGLE_EN
        in_ready = rst_n & ena & settled & (ack_s == tx_req);
`else
        in_ready = rst_n & ena & settled & ~ack_s;
`endif
        if (in_ready && in_valid) state_nxt = SETUP;
      end
`ifdef CDC_TX_TOGGLE_EN
      SETUP: begin
        state_nxt = WAIT;
        req_nxt   = ~tx_req;
      end
      WAIT: begin
        if (ack_s == tx_req) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
`else
      SETUP: begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
      end
      REQ: begin
        if (ack_s) begin
          state_nxt = REL;
          req_nxt   = 1'b0;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_ready & in_valid;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      sent_count <= '0;
    end else begin
      state  <= state_nxt;
      tx_req <= req_nxt;
      if (accept) tx_data <= in_data;
      if (done)   sent_count <= sent_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Testbench for cdc_handshake_tx: protocol-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations (either protocol build).
`timescale 1ns/1ps
module tb_cdc_handshake_tx;
  localparam int S = 2;
`ifdef CDC_TX_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
  localparam int TURN   = 2 + (S + 1);
`else
  localparam bit TOGGLE = 1'b0;
  localparam int TURN   = 2 + 2 * (S + 1);
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       tx_ack = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx_req, busy;
  logic [7:0] tx_data, sent_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
    .busy(busy), .sent_count(sent_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver stand-in: echoes tx_req onto tx_ack after resp_delay cycles, or holds a fixed level.
  bit   resp_hold  = 1'b0;
  logic resp_val   = 1'b0;
  int   resp_delay = 0;
  int   resp_cnt   = 0;
  always @(negedge clk) begin
    if (resp_hold) tx_ack = resp_val;
    else if (tx_ack !== tx_req) begin
      if (resp_cnt >= resp_delay) begin
        tx_ack   = tx_req;
        resp_cnt = 0;
      end else resp_cnt++;
    end else resp_cnt = 0;
  end

  // Reference model: phase 0 idle, 1 data setup, 2 request out, 3 release (four-phase only).
  int         m_phase  = 0;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_count  = 8'h00;
  logic       m_req    = 1'b0;
  logic [3:0] m_hist   = 4'h0;
  int         m_settle = 0;
  logic       m_acks;

  function automatic logic expReady();
    logic a = m_hist[S-1];
    return rst_n && ena && (m_phase == 0) && (m_settle >= S) && (TOGGLE ? (a == m_req) : !a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_data = 8'h00; m_count = 8'h00; m_req = 1'b0; m_hist = 4'h0; m_settle = 0;
    end else begin
      m_acks = m_hist[S-1];
      case (m_phase)
        0: if (expReady() && in_valid) begin
             m_data  = in_data;
             m_phase = 1;
           end
        1: begin
             m_phase = 2;
             m_req   = TOGGLE ? ~m_req : 1'b1;
           end
        2: if (TOGGLE && (m_acks == m_req)) begin
             m_phase = 0;
             m_count = m_count + 8'd1;
           end else if (!TOGGLE && m_acks) begin
             m_phase = 3;
             m_req   = 1'b0;
           end
        3: if (!m_acks) begin
             m_phase = 0;
             m_count = m_count + 8'd1;
           end
        default: m_phase = 0;
      endcase
      m_hist = {m_hist[2:0], tx_ack};
      if (m_settle < S) m_settle++;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("model tx_data", tx_data, m_data);
      checkOutput("model tx_req", tx_req, m_req);
      checkOutput("model in_ready", in_ready, expReady());
      checkOutput("model busy", busy, m_phase != 0);
      checkOutput("model sent_count", sent_count, m_count);
    end
  end

  int         acc_cyc[$];
  logic [7:0] acc_data[$];
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc_cyc.push_back(cyc);
      acc_data.push_back(in_data);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
    in_valid = v;
    in_data  = d;
    ena      = e;
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step(1);
      n++;
    end
    checkOutput(name, busy, 1'b0);
  endtask

  task automatic waitReady(input string name, input int limit);
    int n = 0;
    while (!in_ready && n < limit) begin
      step(1);
      n++;
    end
    checkOutput(name, in_ready, 1'b1);
  endtask

  initial begin
    $display("[TB] start, toggle build=%0d", TOGGLE);
    applyStimulus(1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    step(3);
    checkOutput("reset tx_req", tx_req, 1'b0);
    checkOutput("reset tx_data", tx_data, 8'h00);
    checkOutput("reset in_ready", in_ready, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset sent_count", sent_count, 8'h00);
    rst_n = 1'b1;
    checkOutput("release in_ready held", in_ready, 1'b0);
    step(S);
    checkOutput("settled in_ready", in_ready, 1'b1);

    // First word with a 3-cycle responder.
    resp_delay = 3;
    applyStimulus(1'b1, 8'hAB, 1'b1);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("s1 tx_data", tx_data, 8'hAB);
    checkOutput("s1 tx_req setup", tx_req, 1'b0);
    checkOutput("s1 busy", busy, 1'b1);
    step(1);
    checkOutput("s1 tx_req rise", tx_req, 1'b1);
    waitIdle("s1 complete", 60);
    checkOutput("s1 sent_count", sent_count, 8'd1);
    checkOutput("s1 in_ready", in_ready, 1'b1);
    checkOutput("s1 tx_req final", tx_req, TOGGLE);

    // Data stability while the acknowledge is withheld.
    resp_hold = 1'b1;
    resp_val  = tx_ack;
    applyStimulus(1'b1, 8'hAB, 1'b1);
    step(1);
    applyStimulus(1'b1, 8'h55, 1'b1);
    step(1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 8'hAA : 8'h55, 1'b1);
      step(1);
      checkOutput("hold tx_data", tx_data, 8'hAB);
      checkOutput("hold in_ready", in_ready, 1'b0);
      checkOutput("hold tx_req", tx_req, !TOGGLE);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    resp_hold  = 1'b0;
    resp_delay = 0;
    waitIdle("hold complete", 40);
    checkOutput("hold sent_count", sent_count, 8'd2);

    // Back-to-back stream with an instantaneous responder.
    acc_cyc.delete();
    acc_data.delete();
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(1'b1, 8'(w), 1'b1);
      waitReady("b2b ready", 40);
      step(1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitIdle("b2b complete", 40);
    checkOutput("b2b accepts", acc_cyc.size(), 5);
    for (int i = 0; i < acc_cyc.size(); i++) begin
      checkOutput("b2b order", acc_data[i], i + 1);
      if (i > 0) checkOutput("b2b spacing", acc_cyc[i] - acc_cyc[i-1], TURN);
    end
    checkOutput("b2b sent_count", sent_count, 8'd7);

    // Enable low blocks acceptance; dropping it mid-transfer does not.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    step(4);
    checkOutput("ena0 tx_data", tx_data, 8'h05);
    checkOutput("ena0 busy", busy, 1'b0);
    checkOutput("ena0 in_ready", in_ready, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ena drop busy", busy, 1'b1);
    waitIdle("ena drop complete", 40);
    checkOutput("ena drop sent_count", sent_count, 8'd8);
    checkOutput("ena drop tx_data", tx_data, 8'h3C);

    // Reset during the request phase with the acknowledge stuck high.
    applyStimulus(1'b1, 8'h77, 1'b1);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    resp_hold = 1'b1;
    resp_val  = 1'b1;
    step(2);
    checkOutput("stuck tx_req before reset", tx_req, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset tx_req", tx_req, 1'b0);
    checkOutput("async reset busy", busy, 1'b0);
    checkOutput("async reset sent_count", sent_count, 8'd0);
    step(2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("stuck ack blocks", in_ready, 1'b0);
    end
    resp_val = 1'b0;
    step(1);
    checkOutput("ack falling blocks", in_ready, 1'b0);
    step(1);
    checkOutput("ack low ready", in_ready, 1'b1);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    resp_hold = 1'b0;
    waitIdle("post-reset complete", 40);
    checkOutput("post-reset sent_count", sent_count, 8'd1);
    checkOutput("post-reset tx_data", tx_data, 8'h99);

    // Counter wrap after 256 transfers from reset.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(S);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1);
      waitReady("wrap ready", 40);
      step(1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitIdle("wrap complete", 40);
    checkOutput("wrap sent_count", sent_count, 8'd0);
    checkOutput("wrap tx_data", tx_data, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
